exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage MIPS pipeline. It consumes the registered outputs of the ID/EXE pipeline register and computes ALU results, load/store addresses and link values. It owns the HI/LO registers and an iterative 32-step divider. It drives the EX→ID forwarding bus, plus a stall request to the CRTL unit while a division is in flight.

## Interface
- `DIV_CYCLES`, default 32: number of divider iteration steps; fixed to the operand width.
- `clk`  in  1  pipeline clock (`clk_out1` of `cpuclk`).
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  global stall from CRTL; freezes HI/LO writes of non-divide ops.
- `exe_aluop`  in  6  operation code from ID/EXE.
- `exe_inst`  in  32  instruction word; `[15:0]` is the load/store offset.
- `exe_reg_1`, `exe_reg_2`  in  32  operands. ID has already substituted immediates or shamt (shamt is in `reg_1[4:0]`).
- `exe_write_reg`  in  5  destination register.
- `exe_we`  in  1  register write enable.
- `exe_link_addr`  in  32  return address for JAL/JALR.
- `fwd_we`, `fwd_write_reg`, `fwd_write_data`  out  1/5/32  forwarding bus to ID. `fwd_we` is low while the divider is busy.
- `mem_aluop`  out  6  passed through to the EX/MEM register.
- `mem_addr`  out  32  effective address.
- `mem_store_data`  out  32  `exe_reg_2` for stores.
- `is_load`  out  1  high for LW; drives ID `last_is_load`.
- `stall_req_exe`  out  1  stall request to CRTL.

## Operation
- **aluop codes:**
  - 00 NOP; 01 ADDU; 02 SUBU; 03 AND; 04 OR; 05 XOR; 06 NOR
  - 07 SLT (signed); 08 SLTU; 09 SLL; 0A SRL; 0B SRA; 0C LUI (`reg_2<<16`)
  - 0D MFHI; 0E MFLO; 0F MTHI; 10 MTLO; 11 MULT; 12 MULTU; 13 DIV; 14 DIVU
  - 15 LINK (result = `exe_link_addr`); 16 LW; 17 SW
  - Any other code behaves as NOP.
- **Arithmetic:** 32-bit wraparound, no overflow trap. Shifts use `reg_1[4:0]`, shifted value is `reg_2`.
- **Address:** LW/SW address = `reg_1 + sign_extend(inst[15:0])`. `mem_addr` is 0 for other ops.
- **Multiply:** MULT/MULTU compute the 64-bit product in one cycle with the `*` operator; `{HI,LO}` is written at the clock edge.
  - MTHI/MTLO write `reg_1` to HI/LO.
  - None of these writes occurs while `stall` is high.
- **Register reads:** MFHI/MFLO read the registered HI/LO. A write from the previous instruction is therefore already visible.
- **Divider FSM:** states IDLE, BUSY, DONE.
  - IDLE→BUSY when aluop is DIV/DIVU and the divisor ≠ 0. At that edge, latch |dividend|, |divisor|, the sign flags and the step counter = 0.
  - BUSY: one restoring shift-subtract step per cycle. BUSY→DONE after step `DIV_CYCLES-1`.
  - DONE: fix the signs (quotient negated if the operand signs differ; remainder takes the dividend's sign), write HI = remainder and LO = quotient, then go to IDLE.
  - Divisor = 0: IDLE→DONE directly, with LO = 32'hFFFF_FFFF and HI = dividend.
- **Operand capture:** inputs are ignored during BUSY; the latched operands are used.
- **`stall_req_exe`:** combinational. High in IDLE when a DIV/DIVU is presented, and throughout BUSY. Low in DONE, so the divide retires at the end of the DONE cycle and is not restarted.
- **Forwarding:** `fwd_we` = `exe_we & ~stall_req_exe`. `fwd_write_data` is the ALU/link/MF result; `fwd_write_reg` = `exe_write_reg`.

## Timing
- All outputs except HI/LO and divider state are combinational from the inputs.
- **Reset:** HI = LO = 0, FSM = IDLE, counter = 0, `stall_req_exe` = 0. While `rst` is high, all other outputs are forced to 0.
- **Divide latency** (`DIV_CYCLES` = 32), counted from the first cycle the DIV is in EXE:
  - 1 IDLE cycle + 32 BUSY cycles + 1 DONE cycle = 34 cycles.
  - `stall_req_exe` is high for 33 cycles.
  - HI/LO are valid in the cycle after DONE.
- **Divide by zero:** 2 cycles in EXE, `stall_req_exe` high for 1 cycle.
- **Reset mid-division:** aborts immediately to IDLE; HI/LO return to 0.
- **Back-to-back DIVs:** the second divide starts in the IDLE cycle that follows DONE.

## Configuration
- **`EXE_DIV_EN` defined:** the divider FSM and DIV/DIVU are implemented as above.
- **`EXE_DIV_EN` undefined:** no divider logic is synthesised.
  - DIV/DIVU behave as NOP: HI/LO are unchanged and `stall_req_exe` is tied to 0.
  - FSM and counter registers are absent.

## Test plan
- ADDU `reg_1`=32'h7FFF_FFFF, `reg_2`=1 → `fwd_write_data`=32'h8000_0000, `fwd_we`=1, `stall_req_exe`=0.
- SW with `reg_1`=32'h100, `inst[15:0]`=16'hFFFC, `reg_2`=32'hDEAD → `mem_addr`=32'hFC, `mem_store_data`=32'hDEAD, `is_load`=0.
- MULT −3 × 5, then MFLO next cycle → LO=32'hFFFF_FFF1. MFHI → 32'hFFFF_FFFF.
- DIV −7 / 2 → `stall_req_exe` high for exactly 33 cycles, then HI=32'hFFFF_FFFF (−1) and LO=32'hFFFF_FFFD (−3).
  - Repeat with `EXE_DIV_EN` undefined → no stall, HI/LO unchanged.
- DIVU 10 / 0 → 1 stall cycle, LO=32'hFFFF_FFFF, HI=10.
- Assert `rst` at BUSY step 15 → next cycle `stall_req_exe`=0, HI=LO=0. A DIVU 100/7 issued after release → LO=14, HI=2.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with ALU, address/link generation, HI/LO and an iterative divider.
// Define EXE_DIV_EN to build the DIV/DIVU state machine; otherwise DIV/DIVU act as NOP.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [5:0]  exe_aluop,
  input  logic [31:0] exe_inst,
  input  logic [31:0] exe_reg_1,
  input  logic [31:0] exe_reg_2,
  input  logic [4:0]  exe_write_reg,
  input  logic        exe_we,
  input  logic [31:0] exe_link_addr,
  output logic        fwd_we,
  output logic [4:0]  fwd_write_reg,
  output logic [31:0] fwd_write_data,
  output logic [5:0]  mem_aluop,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  output logic        is_load,
  output logic        stall_req_exe
);

  localparam logic [5:0] OP_ADDU  = 6'h01, OP_SUBU = 6'h02, OP_AND  = 6'h03, OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR   = 6'h05, OP_NOR  = 6'h06, OP_SLT  = 6'h07, OP_SLTU = 6'h08;
  localparam logic [5:0] OP_SLL   = 6'h09, OP_SRL  = 6'h0A, OP_SRA  = 6'h0B, OP_LUI  = 6'h0C;
  localparam logic [5:0] OP_MFHI  = 6'h0D, OP_MFLO = 6'h0E, OP_MTHI = 6'h0F, OP_MTLO = 6'h10;
  localparam logic [5:0] OP_MULT  = 6'h11, OP_MULTU = 6'h12;
  localparam logic [5:0] OP_LINK  = 6'h15, OP_LW   = 6'h16, OP_SW   = 6'h17;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] alu_res;
  logic [63:0] prod_s, prod_u;
  logic        stall_req;
  logic        div_wr;
  logic [31:0] div_hi, div_lo;
  logic        unused_s;

  assign unused_s = ^{exe_inst[31:16], DIV_CYCLES[0]};

  assign prod_s = {{32{exe_reg_1[31]}}, exe_reg_1} * {{32{exe_reg_2[31]}}, exe_reg_2};
  assign prod_u = {32'h0, exe_reg_1} * {32'h0, exe_reg_2};

  // ALU, shifter, link and HI/LO read result selection
  always_comb begin
    alu_res = 32'h0;
    case (exe_aluop)
      OP_ADDU: alu_res = exe_reg_1 + exe_reg_2;
      OP_SUBU: alu_res = exe_reg_1 - exe_reg_2;
      OP_AND:  alu_res = exe_reg_1 & exe_reg_2;
      OP_OR:   alu_res = exe_reg_1 | exe_reg_2;
      OP_XOR:  alu_res = exe_reg_1 ^ exe_reg_2;
      OP_NOR:  alu_res = ~(exe_reg_1 | exe_reg_2);
      OP_SLT:  alu_res = {31'h0, $signed(exe_reg_1) < $signed(exe_reg_2)};
      OP_SLTU: alu_res = {31'h0, exe_reg_1 < exe_reg_2};
      OP_SLL:  alu_res = exe_reg_2 << exe_reg_1[4:0];
      OP_SRL:  alu_res = exe_reg_2 >> exe_reg_1[4:0];
      OP_SRA:  alu_res = $signed(exe_reg_2) >>> exe_reg_1[4:0];
      OP_LUI:  alu_res = exe_reg_2 << 5'd16;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_LINK: alu_res = exe_link_addr;
      default: alu_res = 32'h0;
    endcase
  end

`ifdef EXE_DIV_EN
  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [5:0] OP_DIV = 6'h13, OP_DIVU = 6'h14;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             is_div, is_sdiv;
  logic [32:0]      trial;

  assign is_div  = (exe_aluop == OP_DIV) || (exe_aluop == OP_DIVU);
  assign is_sdiv = (exe_aluop == OP_DIV);
  assign trial   = {rem_q, dvd_q[31]} - {1'b0, dvs_q};

  // Divider next state: dvd_q shifts quotient bits in as the dividend shifts out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div_wr  = 1'b0;
    div_hi  = 32'h0;
    div_lo  = 32'h0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div && (exe_reg_2 == 32'h0)) begin
          state_d = DIV_DONE;
          dvd_d   = 32'hFFFF_FFFF;
          rem_d   = exe_reg_1;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
        end else if (is_div) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          rem_d   = 32'h0;
          dvd_d   = (is_sdiv && exe_reg_1[31]) ? (32'h0 - exe_reg_1) : exe_reg_1;
          dvs_d   = (is_sdiv && exe_reg_2[31]) ? (32'h0 - exe_reg_2) : exe_reg_2;
          qneg_d  = is_sdiv && (exe_reg_1[31] ^ exe_reg_2[31]);
          rneg_d  = is_sdiv && exe_reg_1[31];
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], dvd_q[31]};
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = DIV_DONE;
        end else begin
          state_d = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        div_wr  = 1'b1;
        div_lo  = qneg_q ? (32'h0 - dvd_q) : dvd_q;
        div_hi  = rneg_q ? (32'h0 - rem_q) : rem_q;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign stall_req = ((state_q == DIV_IDLE) && is_div) || (state_q == DIV_BUSY);
`else
  assign stall_req = 1'b0;
  assign div_wr    = 1'b0;
  assign div_hi    = 32'h0;
  assign div_lo    = 32'h0;
`endif

  // HI/LO update: divider completion wins; other writers are frozen by stall
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end else if (!stall) begin
      case (exe_aluop)
        OP_MTHI:  hi_d = exe_reg_1;
        OP_MTLO:  lo_d = exe_reg_1;
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Stage state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
`ifdef EXE_DIV_EN
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= 32'h0;
      dvs_q   <= 32'h0;
      rem_q   <= 32'h0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef EXE_DIV_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  // Output drive, held at zero while reset is asserted
  always_comb begin
    if (rst) begin
      fwd_we         = 1'b0;
      fwd_write_reg  = 5'h0;
      fwd_write_data = 32'h0;
      mem_aluop      = 6'h0;
      mem_addr       = 32'h0;
      mem_store_data = 32'h0;
      is_load        = 1'b0;
      stall_req_exe  = 1'b0;
    end else begin
      fwd_we         = exe_we & ~stall_req;
      fwd_write_reg  = exe_write_reg;
      fwd_write_data = alu_res;
      mem_aluop      = exe_aluop;
      if ((exe_aluop == OP_LW) || (exe_aluop == OP_SW)) begin
        mem_addr = exe_reg_1 + {{16{exe_inst[15]}}, exe_inst[15:0]};
      end else begin
        mem_addr = 32'h0;
      end
      mem_store_data = (exe_aluop == OP_SW) ? exe_reg_2 : 32'h0;
      is_load        = (exe_aluop == OP_LW);
      stall_req_exe  = stall_req;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; expectations follow the EXE_DIV_EN build setting.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [5:0]  exe_aluop;
  logic [31:0] exe_inst, exe_reg_1, exe_reg_2, exe_link_addr;
  logic [4:0]  exe_write_reg;
  logic        exe_we;
  logic        fwd_we;
  logic [4:0]  fwd_write_reg;
  logic [31:0] fwd_write_data, mem_addr, mem_store_data;
  logic [5:0]  mem_aluop;
  logic        is_load, stall_req_exe;

  int n_checks = 0;
  int n_fail   = 0;
  int n_stall;

`ifdef EXE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  exe_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .exe_aluop(exe_aluop), .exe_inst(exe_inst),
    .exe_reg_1(exe_reg_1), .exe_reg_2(exe_reg_2), .exe_write_reg(exe_write_reg),
    .exe_we(exe_we), .exe_link_addr(exe_link_addr), .fwd_we(fwd_we),
    .fwd_write_reg(fwd_write_reg), .fwd_write_data(fwd_write_data), .mem_aluop(mem_aluop),
    .mem_addr(mem_addr), .mem_store_data(mem_store_data), .is_load(is_load),
    .stall_req_exe(stall_req_exe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exe_aluop = op;
    exe_reg_1 = a;
    exe_reg_2 = b;
  endtask

  // advance one clock and present the next op away from the edge
  task automatic next_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    set_op(op, a, b);
    #1;
  endtask

  // count cycles with stall_req_exe high, bounded; returns at the first low cycle
  task automatic count_stall(output int n);
    n = 0;
    while (stall_req_exe && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; exe_inst = 32'h0; exe_write_reg = 5'd3; exe_we = 1'b1;
    exe_link_addr = 32'h0040_0010;
    set_op(6'h13, 32'd9, 32'd3);
    #2;
    check_eq("rst_fwd_data", fwd_write_data, 32'h0);
    check_eq("rst_fwd_we", {31'h0, fwd_we}, 32'h0);
    check_eq("rst_mem_aluop", {26'h0, mem_aluop}, 32'h0);
    check_eq("rst_stall_req", {31'h0, stall_req_exe}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    set_op(6'h0D, 32'h0, 32'h0); #1;
    check_eq("rst_hi", fwd_write_data, 32'h0);
    set_op(6'h0E, 32'h0, 32'h0); #1;
    check_eq("rst_lo", fwd_write_data, 32'h0);

    set_op(6'h01, 32'h7FFF_FFFF, 32'h1); #1;
    check_eq("addu_data", fwd_write_data, 32'h8000_0000);
    check_eq("addu_we", {31'h0, fwd_we}, 32'h1);
    check_eq("addu_reg", {27'h0, fwd_write_reg}, 32'h3);
    check_eq("addu_stall", {31'h0, stall_req_exe}, 32'h0);
    exe_inst = 32'h0000_FFFC;
    set_op(6'h17, 32'h100, 32'hDEAD); #1;
    check_eq("sw_addr", mem_addr, 32'hFC);
    check_eq("sw_data", mem_store_data, 32'hDEAD);
    check_eq("sw_is_load", {31'h0, is_load}, 32'h0);
    exe_inst = 32'h0000_0010;
    set_op(6'h16, 32'h1000, 32'h0); #1;
    check_eq("lw_addr", mem_addr, 32'h1010);
    check_eq("lw_is_load", {31'h0, is_load}, 32'h1);
    set_op(6'h01, 32'h1000, 32'h0); #1;
    check_eq("addu_no_addr", mem_addr, 32'h0);
    exe_inst = 32'h0;

    set_op(6'h02, 32'h0, 32'h1); #1;          check_eq("subu", fwd_write_data, 32'hFFFF_FFFF);
    set_op(6'h07, 32'hFFFF_FFFF, 32'h1); #1;  check_eq("slt", fwd_write_data, 32'h1);
    set_op(6'h08, 32'hFFFF_FFFF, 32'h1); #1;  check_eq("sltu", fwd_write_data, 32'h0);
    set_op(6'h0B, 32'h4, 32'h8000_0000); #1;  check_eq("sra", fwd_write_data, 32'hF800_0000);
    set_op(6'h0A, 32'h4, 32'h8000_0000); #1;  check_eq("srl", fwd_write_data, 32'h0800_0000);
    set_op(6'h09, 32'h24, 32'h1); #1;         check_eq("sll_shamt5", fwd_write_data, 32'h10);
    set_op(6'h0C, 32'h0, 32'h1234); #1;       check_eq("lui", fwd_write_data, 32'h1234_0000);
    set_op(6'h06, 32'hF0F0_0000, 32'h0); #1;  check_eq("nor", fwd_write_data, 32'h0F0F_FFFF);
    set_op(6'h05, 32'hFF00, 32'h0FF0); #1;    check_eq("xor", fwd_write_data, 32'hF0F0);
    set_op(6'h03, 32'hFF00, 32'h0FF0); #1;    check_eq("and", fwd_write_data, 32'h0F00);
    set_op(6'h04, 32'hFF00, 32'h0FF0); #1;    check_eq("or", fwd_write_data, 32'hFFF0);
    set_op(6'h15, 32'h5, 32'h6); #1;          check_eq("link", fwd_write_data, 32'h0040_0010);
    set_op(6'h3F, 32'h5, 32'h6); #1;          check_eq("undef_op", fwd_write_data, 32'h0);

    set_op(6'h12, 32'hFFFF_FFFF, 32'h2);
    next_op(6'h0D, 32'h0, 32'h0);             check_eq("multu_hi", fwd_write_data, 32'h1);
    set_op(6'h0E, 32'h0, 32'h0); #1;          check_eq("multu_lo", fwd_write_data, 32'hFFFF_FFFE);
    set_op(6'h11, 32'hFFFF_FFFD, 32'h5);
    next_op(6'h0E, 32'h0, 32'h0);             check_eq("mult_lo", fwd_write_data, 32'hFFFF_FFF1);
    set_op(6'h0D, 32'h0, 32'h0); #1;          check_eq("mult_hi", fwd_write_data, 32'hFFFF_FFFF);
    stall = 1'b1;
    set_op(6'h0F, 32'hAAAA, 32'h0);
    next_op(6'h0D, 32'h0, 32'h0);             check_eq("mthi_stalled", fwd_write_data, 32'hFFFF_FFFF);
    stall = 1'b0;
    set_op(6'h0F, 32'hAAAA, 32'h0);
    next_op(6'h0D, 32'h0, 32'h0);             check_eq("mthi", fwd_write_data, 32'hAAAA);

    // DIV -7 / 2
    next_op(6'h13, 32'hFFFF_FFF9, 32'h2);
    check_eq("div_fwd_we", {31'h0, fwd_we}, DIV_EN ? 32'h0 : 32'h1);
    count_stall(n_stall);
    check_eq("div_stall_cycles", 32'(n_stall), DIV_EN ? 32'd33 : 32'd0);
    next_op(6'h0D, 32'h0, 32'h0);             check_eq("div_hi", fwd_write_data, DIV_EN ? 32'hFFFF_FFFF : 32'hAAAA);
    set_op(6'h0E, 32'h0, 32'h0); #1;          check_eq("div_lo", fwd_write_data, DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFF1);

    // DIVU 10 / 0
    next_op(6'h14, 32'd10, 32'h0);
    count_stall(n_stall);
    check_eq("div0_stall_cycles", 32'(n_stall), DIV_EN ? 32'd1 : 32'd0);
    next_op(6'h0E, 32'h0, 32'h0);             check_eq("div0_lo", fwd_write_data, DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFF1);
    set_op(6'h0D, 32'h0, 32'h0); #1;          check_eq("div0_hi", fwd_write_data, DIV_EN ? 32'd10 : 32'hAAAA);

    // reset at BUSY step 15
    next_op(6'h13, 32'hFFFF_FFF9, 32'h2);
    repeat (16) @(posedge clk);
    #1; rst = 1'b1;
    #1; check_eq("rst_mid_div_stall", {31'h0, stall_req_exe}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    set_op(6'h00, 32'h0, 32'h0); #1;
    check_eq("post_rst_stall", {31'h0, stall_req_exe}, 32'h0);
    set_op(6'h0D, 32'h0, 32'h0); #1;          check_eq("post_rst_hi", fwd_write_data, 32'h0);
    set_op(6'h0E, 32'h0, 32'h0); #1;          check_eq("post_rst_lo", fwd_write_data, 32'h0);

    // DIVU 100 / 7
    next_op(6'h14, 32'd100, 32'd7);
    count_stall(n_stall);
    check_eq("divu_stall_cycles", 32'(n_stall), DIV_EN ? 32'd33 : 32'd0);
    next_op(6'h0E, 32'h0, 32'h0);             check_eq("divu_lo", fwd_write_data, DIV_EN ? 32'd14 : 32'h0);
    set_op(6'h0D, 32'h0, 32'h0); #1;          check_eq("divu_hi", fwd_write_data, DIV_EN ? 32'd2 : 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
